// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
// Shared types and constants for the pipeline stall/flush controller.
//   state_t      : controller FSM states (IDLE, MC_WAIT)
//   STL_*        : bit positions inside the 6-bit stall vector {wb,mem,ex,id,if,pc}
//   STALL_*      : the three stall vectors the controller ever drives
package pipe_ctrl_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MC_WAIT = 1'b1
  } state_t;

  localparam int STL_PC  = 0;
  localparam int STL_IF  = 1;
  localparam int STL_ID  = 2;
  localparam int STL_EX  = 3;
  localparam int STL_MEM = 4;
  localparam int STL_WB  = 5;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;

endpackage

// File: rtl/pipe_ctrl_mc_cnt.sv
// pipe_ctrl_mc_cnt
// Down-counter that tracks the remaining MC_WAIT cycles of a multicycle
// EX operation. Clear has priority over load, load over decrement.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   clr        : force the count to zero
//   load       : load load_val
//   load_val   : value loaded with load
//   dec        : decrement by one
//   last       : count currently equals 1 (final MC_WAIT cycle)
module pipe_ctrl_mc_cnt #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         last
);

  logic [W-1:0] cnt;

  // Counter register; the controller only decrements while cnt >= 1,
  // so the value never wraps below zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign last = (cnt == W'(1));

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl
// Central stall/flush controller of the five-stage pipeline. Merges the ID
// load-use stall request with multicycle EX operations into one stall vector
// and converts taken branches / exceptions into flush pulses plus a PC redirect.
// Priority each cycle: exception > branch > multicycle > ID hazard.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   stallreq_id_i     : load-use hazard in ID (level)
//   mc_start_i        : EX starts a multicycle op (pulse)
//   mc_cycles_i       : total EX occupancy N of that op
//   branch_i          : taken branch/jump from EX
//   branch_target_i   : branch destination
//   excp_i            : precise exception from MEM
//   excp_vec_i        : exception handler address
//   stall_o           : {wb,mem,ex,id,if,pc} stall vector
//   flush_front_o     : clear if_id and id_ex
//   flush_all_o       : clear if_id, id_ex, ex_mem, mem_wb
//   pc_load_o         : PC loads new_pc_o at next edge
//   new_pc_o          : redirect address (0 when pc_load_o=0)
//   mc_busy_o         : multicycle stall in progress
//   mc_abort_o        : registered pulse, multicycle op killed by exception
//   stall_cnt_o       : (CTRL_PERF_CNT_EN only) cycles with any stall
//   flush_cnt_o       : (CTRL_PERF_CNT_EN only) cycles with flush_front_o
// Optional feature macro: CTRL_PERF_CNT_EN (performance counters).
`ifndef RegBus
`define RegBus 31:0
`endif
`ifndef ZeroWord
`define ZeroWord 32'h0000_0000
`endif

module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MC_CNT_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stallreq_id_i,
  input  logic                mc_start_i,
  input  logic [MC_CNT_W-1:0] mc_cycles_i,
  input  logic                branch_i,
  input  logic [`RegBus]      branch_target_i,
  input  logic                excp_i,
  input  logic [`RegBus]      excp_vec_i,
  output logic [5:0]          stall_o,
  output logic                flush_front_o,
  output logic                flush_all_o,
  output logic                pc_load_o,
  output logic [`RegBus]      new_pc_o,
  output logic                mc_busy_o,
  output logic                mc_abort_o
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0]         stall_cnt_o,
  output logic [31:0]         flush_cnt_o
`endif
);

  state_t state;
  state_t next_state;

  logic                cnt_clr;
  logic                cnt_load;
  logic                cnt_dec;
  logic [MC_CNT_W-1:0] cnt_load_val;
  logic                cnt_last;
  logic                abort_next;

  pipe_ctrl_mc_cnt #(
    .W(MC_CNT_W)
  ) u_mc_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .last     (cnt_last)
  );

  // State register and the registered abort pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      mc_abort_o <= 1'b0;
    end else begin
      state      <= next_state;
      mc_abort_o <= abort_next;
    end
  end

  // Next-state and output decode. Outputs are forced to zero while rst is
  // high so the consuming registers see a quiet controller during reset.
  // The start cycle of a multicycle op already stalls, so MC_WAIT only has
  // to cover the remaining N-2 cycles; N<=2 never leaves IDLE.
  always_comb begin
    next_state    = state;
    stall_o       = STALL_NONE;
    flush_front_o = 1'b0;
    flush_all_o   = 1'b0;
    pc_load_o     = 1'b0;
    new_pc_o      = `ZeroWord;
    mc_busy_o     = 1'b0;
    cnt_clr       = 1'b0;
    cnt_load      = 1'b0;
    cnt_dec       = 1'b0;
    cnt_load_val  = mc_cycles_i - MC_CNT_W'(2);
    abort_next    = 1'b0;

    if (rst) begin
      next_state = IDLE;
    end else if (excp_i) begin
      flush_all_o   = 1'b1;
      flush_front_o = 1'b1;
      pc_load_o     = 1'b1;
      new_pc_o      = excp_vec_i;
      next_state    = IDLE;
      cnt_clr       = 1'b1;
      abort_next    = (state == MC_WAIT) || mc_start_i;
    end else if (branch_i && (state == IDLE)) begin
      flush_front_o = 1'b1;
      pc_load_o     = 1'b1;
      new_pc_o      = branch_target_i;
    end else if (state == MC_WAIT) begin
      stall_o   = STALL_EX;
      mc_busy_o = 1'b1;
      cnt_dec   = 1'b1;
      if (cnt_last) begin
        next_state = IDLE;
      end
    end else if (mc_start_i) begin
      if (mc_cycles_i >= MC_CNT_W'(2)) begin
        stall_o   = STALL_EX;
        mc_busy_o = 1'b1;
      end
      if (mc_cycles_i >= MC_CNT_W'(3)) begin
        cnt_load   = 1'b1;
        next_state = MC_WAIT;
      end
    end else if (stallreq_id_i) begin
      stall_o = STALL_ID;
    end
  end

`ifdef CTRL_PERF_CNT_EN
  // Free-running event counters, wrapping modulo 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_o <= 32'd0;
      flush_cnt_o <= 32'd0;
    end else begin
      if (stall_o != STALL_NONE) begin
        stall_cnt_o <= stall_cnt_o + 32'd1;
      end
      if (flush_front_o) begin
        flush_cnt_o <= flush_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl
// Self-checking bench for pipe_ctrl: directed steps followed by random
// traffic, compared every cycle against a reference model that tracks the
// number of remaining multicycle stall cycles as a plain integer.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_id_i;
  logic        mc_start_i;
  logic [5:0]  mc_cycles_i;
  logic        branch_i;
  logic [31:0] branch_target_i;
  logic        excp_i;
  logic [31:0] excp_vec_i;
  logic [5:0]  stall_o;
  logic        flush_front_o;
  logic        flush_all_o;
  logic        pc_load_o;
  logic [31:0] new_pc_o;
  logic        mc_busy_o;
  logic        mc_abort_o;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] stall_cnt_o;
  logic [31:0] flush_cnt_o;
`endif

  int checks = 0;
  int fails  = 0;

  // reference model state
  int          rem;
  logic        abort_q;
  int          m_stall_cnt;
  int          m_flush_cnt;
  // reference model combinational results
  logic [5:0]  e_stall;
  logic        e_ff;
  logic        e_fa;
  logic        e_pl;
  logic [31:0] e_pc;
  logic        e_busy;
  int          n_rem;
  logic        n_abort;

  pipe_ctrl #(.MC_CNT_W(6)) dut (
    .clk             (clk),
    .rst             (rst),
    .stallreq_id_i   (stallreq_id_i),
    .mc_start_i      (mc_start_i),
    .mc_cycles_i     (mc_cycles_i),
    .branch_i        (branch_i),
    .branch_target_i (branch_target_i),
    .excp_i          (excp_i),
    .excp_vec_i      (excp_vec_i),
    .stall_o         (stall_o),
    .flush_front_o   (flush_front_o),
    .flush_all_o     (flush_all_o),
    .pc_load_o       (pc_load_o),
    .new_pc_o        (new_pc_o),
    .mc_busy_o       (mc_busy_o),
    .mc_abort_o      (mc_abort_o)
`ifdef CTRL_PERF_CNT_EN
    ,
    .stall_cnt_o     (stall_cnt_o),
    .flush_cnt_o     (flush_cnt_o)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model of one cycle, derived from the priority rules:
  // rem = stall cycles still owed after the start cycle.
  task automatic modelComb();
    e_stall = 6'b000000;
    e_ff    = 1'b0;
    e_fa    = 1'b0;
    e_pl    = 1'b0;
    e_pc    = 32'h0;
    e_busy  = 1'b0;
    n_rem   = rem;
    n_abort = 1'b0;
    if (rst) begin
      n_rem = 0;
    end else if (excp_i) begin
      e_fa    = 1'b1;
      e_ff    = 1'b1;
      e_pl    = 1'b1;
      e_pc    = excp_vec_i;
      n_abort = (rem > 0) || mc_start_i;
      n_rem   = 0;
    end else if (branch_i && rem == 0) begin
      e_ff = 1'b1;
      e_pl = 1'b1;
      e_pc = branch_target_i;
    end else if (rem > 0) begin
      e_stall = 6'b001111;
      e_busy  = 1'b1;
      n_rem   = rem - 1;
    end else if (mc_start_i) begin
      if (int'(mc_cycles_i) >= 2) begin
        e_stall = 6'b001111;
        e_busy  = 1'b1;
      end
      n_rem = (int'(mc_cycles_i) >= 3) ? int'(mc_cycles_i) - 2 : 0;
    end else if (stallreq_id_i) begin
      e_stall = 6'b000111;
    end
  endtask

  task automatic modelSeq();
    if (e_stall != 6'b000000) m_stall_cnt++;
    if (e_ff) m_flush_cnt++;
    rem     = n_rem;
    abort_q = n_abort;
  endtask

  task automatic modelReset();
    rem         = 0;
    abort_q     = 1'b0;
    m_stall_cnt = 0;
    m_flush_cnt = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkOutput(input string tag);
    modelComb();
    chk({tag, ".stall"},       32'(stall_o),       32'(e_stall));
    chk({tag, ".flush_front"}, 32'(flush_front_o), 32'(e_ff));
    chk({tag, ".flush_all"},   32'(flush_all_o),   32'(e_fa));
    chk({tag, ".pc_load"},     32'(pc_load_o),     32'(e_pl));
    chk({tag, ".new_pc"},      new_pc_o,           e_pc);
    chk({tag, ".mc_busy"},     32'(mc_busy_o),     32'(e_busy));
    chk({tag, ".mc_abort"},    32'(mc_abort_o),    32'(abort_q));
`ifdef CTRL_PERF_CNT_EN
    chk({tag, ".stall_cnt"},   stall_cnt_o,        32'(m_stall_cnt));
    chk({tag, ".flush_cnt"},   flush_cnt_o,        32'(m_flush_cnt));
`endif
  endtask

  // Drive one cycle of inputs (called 1 time unit after a rising edge),
  // check the outputs mid-cycle, then advance across the next edge.
  task automatic applyStimulus(input string tag, input logic sreq, input logic mcs,
                               input logic [5:0] n, input logic br, input logic [31:0] bt,
                               input logic ex, input logic [31:0] ev);
    stallreq_id_i   = sreq;
    mc_start_i      = mcs;
    mc_cycles_i     = n;
    branch_i        = br;
    branch_target_i = bt;
    excp_i          = ex;
    excp_vec_i      = ev;
    #2;
    checkOutput(tag);
    @(posedge clk);
    modelSeq();
    #1;
  endtask

  task automatic idle(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      applyStimulus(tag, 1'b0, 1'b0, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    end
  endtask

  initial begin
    rst = 1'b1;
    stallreq_id_i = 1'b0; mc_start_i = 1'b0; mc_cycles_i = 6'd0;
    branch_i = 1'b0; branch_target_i = 32'h0; excp_i = 1'b0; excp_vec_i = 32'h0;
    modelReset();
    @(posedge clk);
    #1;
    checkOutput("reset_hold");
    rst = 1'b0;

    // Async reset in the middle of a start cycle
    idle("pre", 1);
    mc_start_i = 1'b1; mc_cycles_i = 6'd5;
    #2;
    checkOutput("rst_pre");
    rst = 1'b1;
    modelReset();
    #1;
    checkOutput("rst_async");
    chk("rst_async.stall_const", 32'(stall_o), 32'h0);
    @(posedge clk);
    #1;
    checkOutput("rst_held");
    rst = 1'b0;
    idle("post_rst", 2);
    chk("post_rst.busy_const", 32'(mc_busy_o), 32'h0);

    // N=5: four stall cycles, then branch with concurrent ID hazard
    applyStimulus("mc5_start", 1'b0, 1'b1, 6'd5, 1'b0, 32'h0, 1'b0, 32'h0);
    idle("mc5_wait", 4);
    applyStimulus("branch", 1'b1, 1'b0, 6'd0, 1'b1, 32'h0000_0100, 1'b0, 32'h0);
`ifdef CTRL_PERF_CNT_EN
    chk("perf.stall_cnt_const", stall_cnt_o, 32'd4);
    chk("perf.flush_cnt_const", flush_cnt_o, 32'd1);
`endif

    // N=2 one stall cycle, N=1 none, N=0 none
    applyStimulus("mc2", 1'b0, 1'b1, 6'd2, 1'b0, 32'h0, 1'b0, 32'h0);
    idle("mc2_after", 1);
    applyStimulus("mc1", 1'b0, 1'b1, 6'd1, 1'b0, 32'h0, 1'b0, 32'h0);
    applyStimulus("mc0", 1'b0, 1'b1, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);

    // Load-use hazard in IDLE and during MC_WAIT
    applyStimulus("lu0", 1'b1, 1'b0, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    applyStimulus("lu1", 1'b1, 1'b0, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    applyStimulus("lu_mc_start", 1'b1, 1'b1, 6'd4, 1'b0, 32'h0, 1'b0, 32'h0);
    applyStimulus("lu_mc_wait", 1'b1, 1'b0, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    applyStimulus("lu_mc_wait2", 1'b1, 1'b1, 6'd9, 1'b1, 32'h44, 1'b0, 32'h0);
    idle("lu_after", 2);

    // Exception in MC_WAIT with cnt=3 (N=6: start, one wait, then excp)
    applyStimulus("ex_mc_start", 1'b0, 1'b1, 6'd6, 1'b0, 32'h0, 1'b0, 32'h0);
    applyStimulus("ex_mc_wait", 1'b0, 1'b0, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);
    applyStimulus("excp", 1'b1, 1'b0, 6'd0, 1'b1, 32'h20, 1'b1, 32'h0000_0008);
    chk("excp.abort_const", 32'(mc_abort_o), 32'h1);
    applyStimulus("post_excp", 1'b1, 1'b0, 6'd0, 1'b0, 32'h0, 1'b0, 32'h0);

    // Exception coinciding with mc_start also aborts; max-length op
    applyStimulus("excp_start", 1'b0, 1'b1, 6'd7, 1'b0, 32'h0, 1'b1, 32'h0000_0080);
    applyStimulus("max_start", 1'b0, 1'b1, 6'd63, 1'b0, 32'h0, 1'b0, 32'h0);
    idle("max_wait", 63);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [5:0] n;
      n = ($urandom_range(0, 15) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 8));
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        modelReset();
        #1;
        checkOutput("rnd_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
      end
      applyStimulus("rnd",
                    ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 7) == 0),
                    n,
                    ($urandom_range(0, 9) == 0),
                    $urandom(),
                    ($urandom_range(0, 19) == 0),
                    $urandom());
    end
    idle("drain", 2);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central stall/flush controller for the five-stage pipeline. It merges hazard stall requests from ID and multicycle-operation requests from EX into one per-stage stall vector, and turns taken branches and exceptions into flush pulses plus a PC redirect. Its outputs drive the PC register and the stall/flush inputs of if_id, id_ex, ex_mem and mem_wb. A small down-counter tracks multicycle EX operations, so EX does not need to hold its own stall request.

## Interface
Parameters:
- MC_CNT_W, 6: width of the multicycle length field and the internal counter.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-high reset.
- stallreq_id_i  in  1  load-use hazard in ID; level-sensitive.
- mc_start_i  in  1  one-cycle pulse when EX begins a multicycle operation.
- mc_cycles_i  in  MC_CNT_W  total EX occupancy N of that operation; sampled with mc_start_i.
- branch_i  in  1  EX resolved a taken branch or jump.
- branch_target_i  in  32 (`RegBus`)  branch destination.
- excp_i  in  1  MEM signals a precise exception.
- excp_vec_i  in  32  handler address.
- stall_o  out  6  {wb, mem, ex, id, if, pc}.
- flush_front_o  out  1  clear if_id and id_ex.
- flush_all_o  out  1  clear if_id, id_ex, ex_mem and mem_wb.
- pc_load_o  out  1  PC loads new_pc_o at the next edge.
- new_pc_o  out  32  redirect address.
- mc_busy_o  out  1  a multicycle stall is in progress.
- mc_abort_o  out  1  registered one-cycle pulse: a multicycle operation was killed by an exception.

## Operation
- States: IDLE, MC_WAIT. Counter cnt is MC_CNT_W bits wide.
- Priority, evaluated each cycle: exception > branch > multicycle > ID hazard.
- Exception (excp_i=1, in any state):
  - Outputs: flush_all_o=1, flush_front_o=1, pc_load_o=1, new_pc_o=excp_vec_i, stall_o=000000.
  - State: next state IDLE, cnt cleared.
  - If the state was MC_WAIT or mc_start_i=1 in the same cycle, mc_abort_o pulses in the next cycle.
- Branch (branch_i=1, no exception):
  - Outputs: flush_front_o=1, pc_load_o=1, new_pc_o=branch_target_i, stall_o=000000.
  - stallreq_id_i and mc_start_i are ignored that cycle.
  - branch_i in MC_WAIT is illegal and ignored (EX is frozen).
- Multicycle operation of length N:
  - stall_o=001111 and mc_busy_o=1 for exactly N-1 consecutive cycles, starting with the mc_start_i cycle.
  - In IDLE, on mc_start_i: if N≥3, cnt←N-2 and go to MC_WAIT. If N≤2, stay in IDLE.
  - In MC_WAIT: stall_o=001111. If cnt==1, go to IDLE; else cnt←cnt-1.
  - N=0 and N=1 produce no stall. N=2 produces a stall in the start cycle only.
  - mc_start_i in MC_WAIT is ignored.
- ID hazard (stallreq_id_i=1, IDLE, no higher event): stall_o=000111, which makes id_ex take a bubble. In MC_WAIT, stall_o stays 001111.
- Otherwise all outputs are 0. new_pc_o is 0 whenever pc_load_o=0.

## Timing
- stall_o, flush_*_o, pc_load_o, new_pc_o and mc_busy_o are combinational from the current state and inputs. They take effect at the next clk edge in the consuming registers.
- state, cnt and mc_abort_o are registered.
- Reset: while rst=1, every output is 0, state=IDLE and cnt=0, independent of clk. The first cycle after rst deasserts behaves as IDLE.
- Reset asserted mid-MC_WAIT abandons the count; mc_abort_o does not pulse.
- cnt never wraps: N is clamped to the MC_CNT_W range by its width, and the maximum N gives 2^MC_CNT_W-2 stall cycles.

## Configuration
- CTRL_PERF_CNT_EN defined:
  - Adds outputs stall_cnt_o[31:0] and flush_cnt_o[31:0].
  - stall_cnt_o increments each cycle in which stall_o≠0.
  - flush_cnt_o increments each cycle in which flush_front_o=1.
  - Both wrap modulo 2^32 and reset to 0.
- CTRL_PERF_CNT_EN undefined: the ports and counters do not exist. All other behaviour is identical.

## Structure
- pipe_ctrl_pkg contains:
  - the state enum (IDLE, MC_WAIT);
  - stall index constants STL_PC..STL_WB (0..5);
  - vector constants STALL_NONE=6'b000000, STALL_ID=6'b000111, STALL_EX=6'b001111.
- Shared `RegBus`/`ZeroWord` macros come from port_define.sv.
- One sub-module, pipe_ctrl_mc_cnt, holds the load/decrement/clear counter and its terminal flag. The FSM and priority logic stay in pipe_ctrl.

## Test plan
- Reset: assert rst asynchronously mid-cycle with mc_start_i=1, N=5 → all outputs are 0 immediately. After release, mc_busy_o=0 and no stall occurs.
- Multicycle: mc_start_i with N=5 → stall_o=001111 for exactly 4 cycles, then 000000. N=2 → 1 cycle. N=1 → none.
- Load-use: stallreq_id_i=1 for 2 cycles in IDLE → stall_o=000111 for those 2 cycles. The same request during MC_WAIT → stall_o stays 001111.
- Branch: branch_i=1, branch_target_i=0x0000_0100, stallreq_id_i=1 in the same cycle → flush_front_o=1, pc_load_o=1, new_pc_o=0x100, stall_o=0.
- Exception: excp_i=1, excp_vec_i=0x0000_0008 during MC_WAIT with cnt=3 → flush_all_o=1, new_pc_o=0x8, stall_o=0. mc_abort_o pulses in the next cycle; state is IDLE.
- With CTRL_PERF_CNT_EN: run the N=5 operation plus one branch → stall_cnt_o=4, flush_cnt_o=1.
